upsample_job_scheduler: RTL and testbench

Sequences the `axis_dma_bram_fsm` upsample engine across a multi-channel job. Accepts one job descriptor: a channel count and an upsample size select. For each channel it issues one `start_process` pulse and watches the engine's output stream for the closing TLAST beat, then starts the next channel. Raises a completion pulse at the end of the job, or a sticky timeout error if the engine stalls. Sits between the PS-side control registers and the DMA/BRAM FSM; the AXI-Stream data itself never passes through it.

---
 rtl/upsample_pkg.sv | 43 ++++
 rtl/stall_watchdog.sv | 43 ++++
 rtl/upsample_job_scheduler.sv | 158 +++++++++++++++
 tb/tb_upsample_job_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upsample_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : upsample_pkg
//  Description : Shared types and constants for the upsample job scheduler
//                and the axis_dma_bram_fsm engine it drives.
//                - sched_state_t : scheduler state encoding
//                - SIZE_*        : upsample size-select encodings
//                - DEF_*         : default scheduler timing constants
//  Revision    : 1.0 - initial release
// ============================================================================
package upsample_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ISSUE    = 3'd1,
    WAIT_OUT = 3'd2,
    GAP      = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } sched_state_t;

  // Size-select encodings understood by axis_dma_bram_fsm.
  localparam logic [1:0] SIZE_X2  = 2'd0;
  localparam logic [1:0] SIZE_X4  = 2'd1;
  localparam logic [1:0] SIZE_X8  = 2'd2;
  localparam logic [1:0] SIZE_X16 = 2'd3;

  localparam int DEF_GAP_CYCLES     = 2;
  localparam int DEF_TIMEOUT_CYCLES = 100000;

  // Upsample factor implied by a size-select code.
  function automatic int unsigned upsample_factor(input logic [1:0] sel);
    case (sel)
      SIZE_X2:  return 2;
      SIZE_X4:  return 4;
      SIZE_X8:  return 8;
      SIZE_X16: return 16;
      default:  return 2;
    endcase
  endfunction

endpackage : upsample_pkg
`default_nettype wire

// File: rtl/stall_watchdog.sv
`default_nettype none
// ============================================================================
//  Module      : stall_watchdog
//  Description : Saturating cycle counter used to detect a stalled output
//                stream. Counts up on inc, clears on clr (clr wins), and
//                flags expired once the count sits at TIMEOUT_CYCLES-1.
//  Ports       : clk, aresetn (async active-low)
//                clr     - return count to zero
//                inc     - advance count by one (saturating)
//                expired - count has reached TIMEOUT_CYCLES-1
//  Revision    : 1.0 - initial release
// ============================================================================
module stall_watchdog
  import upsample_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic aresetn,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign expired = (count == CNT_MAX);

endmodule : stall_watchdog
`default_nettype wire

// File: rtl/upsample_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : upsample_job_scheduler
//  Description : Runs the axis_dma_bram_fsm upsample engine once per channel
//                of a job. Issues a start pulse per channel, waits for the
//                closing TLAST on the engine output, inserts an idle gap and
//                moves on. Pulses job_done at the end of the job or raises a
//                sticky err_timeout if the output stream stalls.
//  Ports       : clk, aresetn (async active-low)
//                cfg_valid/cfg_ready, cfg_num_channels, cfg_size_sel - job in
//                abort                 - level-sampled return to IDLE
//                fsm_start_process     - one-cycle engine start
//                fsm_size_sel          - size mode held for the job
//                mon_tvalid/tready/tlast - engine m_axis taps
//                busy, chan_idx, job_done, err_timeout - status
//  Revision    : 1.0 - initial release
// ============================================================================
module upsample_job_scheduler
  import upsample_pkg::*;
#(
  parameter int CH_W           = 8,
  parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic            clk,
  input  logic            aresetn,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CH_W-1:0] cfg_num_channels,
  input  logic [1:0]      cfg_size_sel,
  input  logic            abort,
  output logic            fsm_start_process,
  output logic [1:0]      fsm_size_sel,
  input  logic            mon_tvalid,
  input  logic            mon_tready,
  input  logic            mon_tlast,
  output logic            busy,
  output logic [CH_W-1:0] chan_idx,
  output logic            job_done,
  output logic            err_timeout
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  sched_state_t     state;
  sched_state_t     next_state;
  logic [CH_W-1:0]  num_ch;
  logic [GAP_W-1:0] gap_cnt;
  logic             beat;
  logic             cfg_fire;
  logic             last_ch;
  logic             wd_clr;
  logic             wd_inc;
  logic             wd_expired;

  assign beat     = mon_tvalid & mon_tready;
  // cfg_ready is a register, so accepting a job adds no input->output path.
  assign cfg_fire = cfg_valid & cfg_ready;
  // Only evaluated in WAIT_OUT, where num_ch is known to be non-zero.
  assign last_ch  = (chan_idx == (num_ch - CH_W'(1)));

  assign wd_clr = abort | (state == ISSUE) | ((state == WAIT_OUT) & beat);
  assign wd_inc = (state == WAIT_OUT) & ~beat;

  stall_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_stall_watchdog (
    .clk     (clk),
    .aresetn (aresetn),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_fire) begin
            next_state = (cfg_num_channels != '0) ? ISSUE : DONE;
          end
        end
        ISSUE:    next_state = WAIT_OUT;
        WAIT_OUT: begin
          if (beat && mon_tlast) begin
            next_state = last_ch ? DONE : GAP;
          end else if (!beat && wd_expired) begin
            next_state = ERR;
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            next_state = ISSUE;
          end
        end
        DONE:     next_state = IDLE;
        ERR:      next_state = ERR;
        default:  next_state = IDLE;
      endcase
    end
  end

  // State, datapath and outputs share one register stage; outputs are
  // decoded from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= IDLE;
      num_ch            <= '0;
      gap_cnt           <= '0;
      chan_idx          <= '0;
      fsm_size_sel      <= SIZE_X2;
      cfg_ready         <= 1'b1;
      fsm_start_process <= 1'b0;
      job_done          <= 1'b0;
      err_timeout       <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= next_state;
      cfg_ready         <= (next_state == IDLE);
      fsm_start_process <= (next_state == ISSUE);
      job_done          <= (next_state == DONE);
      err_timeout       <= (next_state == ERR);
      busy              <= (next_state != IDLE) && (next_state != ERR);

      if (abort) begin
        chan_idx <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cfg_fire) begin
              num_ch       <= cfg_num_channels;
              fsm_size_sel <= cfg_size_sel;
              chan_idx     <= '0;
            end
          end
          WAIT_OUT: begin
            if (beat && mon_tlast && !last_ch) begin
              chan_idx <= chan_idx + CH_W'(1);
              gap_cnt  <= GAP_LOAD;
            end
          end
          GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - GAP_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule : upsample_job_scheduler
`default_nettype wire

// File: tb/tb_upsample_job_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_upsample_job_scheduler
//  Description : Self-checking bench for upsample_job_scheduler. A simple
//                engine model streams beats after each start pulse; expected
//                start pulses and job_done pulses are queued as stimulus is
//                driven and consumed by a monitor when the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_upsample_job_scheduler;
  import upsample_pkg::*;

  localparam int CH_W  = 8;
  localparam int GAP   = 2;
  localparam int TMO   = 64;
  localparam int BEATS = 16;

  logic            clk = 1'b0;
  logic            aresetn = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CH_W-1:0] cfg_num_channels = '0;
  logic [1:0]      cfg_size_sel = 2'd0;
  logic            abort = 1'b0;
  logic            fsm_start_process;
  logic [1:0]      fsm_size_sel;
  logic            mon_tvalid = 1'b0;
  logic            mon_tready = 1'b1;
  logic            mon_tlast = 1'b0;
  logic            busy;
  logic [CH_W-1:0] chan_idx;
  logic            job_done;
  logic            err_timeout;

  upsample_job_scheduler #(
    .CH_W           (CH_W),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk               (clk),
    .aresetn           (aresetn),
    .cfg_valid         (cfg_valid),
    .cfg_ready         (cfg_ready),
    .cfg_num_channels  (cfg_num_channels),
    .cfg_size_sel      (cfg_size_sel),
    .abort             (abort),
    .fsm_start_process (fsm_start_process),
    .fsm_size_sel      (fsm_size_sel),
    .mon_tvalid        (mon_tvalid),
    .mon_tready        (mon_tready),
    .mon_tlast         (mon_tlast),
    .busy              (busy),
    .chan_idx          (chan_idx),
    .job_done          (job_done),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int cyc;
    int chan;
  } start_exp_t;

  start_exp_t exp_start[$];
  int         exp_done[$];
  logic [1:0] exp_sel = 2'd0;
  start_exp_t mon_se;

  task automatic check(input string tag, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every start/done pulse must match a queued entry.
  always @(negedge clk) begin
    if (fsm_start_process) begin
      check("start_expected", longint'(exp_start.size() != 0), 1);
      if (exp_start.size() != 0) begin
        mon_se = exp_start.pop_front();
        check("start_cyc", cyc, mon_se.cyc);
        check("start_chan", chan_idx, mon_se.chan);
      end
    end
    if (job_done) begin
      check("done_expected", longint'(exp_done.size() != 0), 1);
      if (exp_done.size() != 0) check("done_cyc", cyc, exp_done.pop_front());
      check("done_busy", busy, 1);
    end
    if (busy) check("size_sel_held", fsm_size_sel, exp_sel);
  end

  // Entered and left just after a rising edge.
  task automatic send_cfg(input int n, input logic [1:0] sel);
    start_exp_t se;
    cfg_valid        = 1'b1;
    cfg_num_channels = CH_W'(n);
    cfg_size_sel     = sel;
    exp_sel          = sel;
    if (n == 0) begin
      exp_done.push_back(cyc + 1);
    end else begin
      se.cyc  = cyc + 1;
      se.chan = 0;
      exp_start.push_back(se);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (fsm_start_process) ok = 1'b1;
    end
    check("start_seen", ok, 1);
    @(posedge clk); #1;
  endtask

  // Engine model: streams up to nbeats beats, TLAST on the last one.
  task automatic stream(input int ch, input int nbeats, input bit last_ch,
                        input bit toggle, input bit abort_last,
                        input int stop_after, input int poke_at,
                        output int last_c);
    int         beat;
    bit         fin;
    bit         lastbeat;
    start_exp_t se;
    beat   = 0;
    fin    = 1'b0;
    last_c = cyc;
    for (int i = 0; i < 400 && !fin; i++) begin
      lastbeat   = (beat == nbeats - 1);
      mon_tvalid = 1'b1;
      mon_tlast  = lastbeat;
      mon_tready = toggle ? cyc[0] : 1'b1;
      abort      = abort_last && lastbeat && mon_tready;
      if (beat == poke_at) begin
        cfg_valid        = 1'b1;
        cfg_num_channels = CH_W'(7);
        cfg_size_sel     = 2'd3;
      end
      last_c = cyc;
      @(posedge clk); #1;
      abort     = 1'b0;
      cfg_valid = 1'b0;
      if (mon_tready) begin
        if (lastbeat) begin
          fin = 1'b1;
          if (!abort_last) begin
            if (last_ch) begin
              exp_done.push_back(last_c + 1);
            end else begin
              se.cyc  = last_c + GAP + 1;
              se.chan = ch + 1;
              exp_start.push_back(se);
            end
          end
        end
        beat++;
        if (beat == stop_after) fin = 1'b1;
      end
    end
    mon_tvalid = 1'b0;
    mon_tlast  = 1'b0;
    mon_tready = 1'b1;
    check("stream_complete", fin, 1);
  endtask

  task automatic run_job(input int n, input logic [1:0] sel, input bit toggle,
                         input int poke_at);
    bit ok;
    int lc;
    send_cfg(n, sel);
    for (int ch = 0; ch < n; ch++) begin
      wait_start(ok);
      if (!ok) break;
      stream(ch, BEATS, ch == n - 1, toggle, 1'b0, 0, (ch == 0) ? poke_at : -1, lc);
    end
    repeat (4) @(posedge clk);
    #1;
    check("idle_ready", cfg_ready, 1);
    check("idle_busy", busy, 0);
    check("start_q_empty", exp_start.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
  endtask

  initial begin
    bit ok;
    int lc;
    int rise;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_start", fsm_start_process, 0);
    check("rst_done", job_done, 0);
    check("rst_err", err_timeout, 0);
    check("rst_busy", busy, 0);
    check("rst_chan", chan_idx, 0);
    check("rst_sel", fsm_size_sel, 0);
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Three-channel job, size_sel=2
    run_job(3, 2'd2, 1'b0, -1);

    // Zero-channel job: done only, no start
    send_cfg(0, 2'd1);
    repeat (3) @(posedge clk);
    #1;
    check("zero_done_q_empty", exp_done.size(), 0);
    check("zero_start_q_empty", exp_start.size(), 0);

    // Back-pressure plus a cfg_valid poke while busy
    run_job(3, 2'd2, 1'b1, 5);

    // Stall after 5 beats -> timeout
    send_cfg(2, 2'd0);
    wait_start(ok);
    stream(0, BEATS, 1'b0, 1'b0, 1'b0, 5, -1, lc);
    ok   = 1'b0;
    rise = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (err_timeout) begin
        ok   = 1'b1;
        rise = cyc;
      end
    end
    check("err_seen", ok, 1);
    check("err_rise_cyc", rise, lc + TMO + 1);
    check("err_busy", busy, 0);
    check("err_cfg_ready", cfg_ready, 0);
    @(posedge clk); #1;
    check("err_sticky", err_timeout, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_err_clr", err_timeout, 0);
    check("abort_err_ready", cfg_ready, 1);

    // Abort in the same cycle as the final TLAST
    send_cfg(2, 2'd1);
    wait_start(ok);
    stream(0, BEATS, 1'b0, 1'b0, 1'b0, 0, -1, lc);
    wait_start(ok);
    stream(1, BEATS, 1'b1, 1'b0, 1'b1, 0, -1, lc);
    check("abort_ready", cfg_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_chan", chan_idx, 0);
    repeat (4) @(posedge clk);
    #1;
    check("abort_done_q_empty", exp_done.size(), 0);
    check("abort_start_q_empty", exp_start.size(), 0);

    // Asynchronous reset during WAIT_OUT on channel 1
    send_cfg(2, 2'd3);
    wait_start(ok);
    stream(0, BEATS, 1'b0, 1'b0, 1'b0, 0, -1, lc);
    wait_start(ok);
    stream(1, BEATS, 1'b1, 1'b0, 1'b0, 5, -1, lc);
    check("pre_rst_chan", chan_idx, 1);
    #2 aresetn = 1'b0;
    #1;
    check("arst_cfg_ready", cfg_ready, 1);
    check("arst_busy", busy, 0);
    check("arst_chan", chan_idx, 0);
    check("arst_sel", fsm_size_sel, 0);
    check("arst_start", fsm_start_process, 0);
    check("arst_err", err_timeout, 0);
    check("arst_start_q_empty", exp_start.size(), 0);
    @(posedge clk); #1;
    aresetn = 1'b1;
    @(posedge clk); #1;

    // Fresh job after reset
    run_job(2, 2'd1, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected 0 (cycles elapsed)", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule : tb_upsample_job_scheduler
`default_nettype wire
